seq_divider_unit: RTL

//   Multi-cycle restoring radix-2 integer divider, parametrised in operand width.

---
 rtl/seq_divider_unit_if.sv | 25 ++
 rtl/seq_divider_unit.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/seq_divider_unit_if.sv
// Request/response bundle between the EX-stage issue logic and the sequential divider.
// The master drives operands and start; the slave reports busy/done and the results.
interface seq_divider_unit_if #(
  parameter int WIDTH = 32
);
  logic             start_signal;
  logic             signed_division;
  logic [WIDTH-1:0] dividend_input;
  logic [WIDTH-1:0] divisor_input;
  logic             busy_signal;
  logic             done_signal;
  logic             div_zero_signal;
  logic [WIDTH-1:0] quotient_output;
  logic [WIDTH-1:0] remainder_output;

  modport master (
    output start_signal, signed_division, dividend_input, divisor_input,
    input  busy_signal, done_signal, div_zero_signal, quotient_output, remainder_output
  );

  modport slave (
    input  start_signal, signed_division, dividend_input, divisor_input,
    output busy_signal, done_signal, div_zero_signal, quotient_output, remainder_output
  );
endinterface

// File: rtl/seq_divider_unit.sv
// Restoring radix-2 divider: one quotient bit per clock, signed or unsigned,
// fixed WIDTH+2 cycle latency from accepted start to the done pulse.
module seq_divider_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clock_signal,
  input  logic               reset_n_signal,
  seq_divider_unit_if.slave  div_bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_POST
  } state_t;

  state_t             state;
  logic               sgn_q;
  logic [WIDTH-1:0]   dvd_q;     // original dividend, kept for the divide-by-zero remainder
  logic [WIDTH-1:0]   dsr_mag;   // raw divisor in PREP, magnitude afterwards
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [CNT_W-1:0]   cnt;
  logic               q_neg;
  logic               r_neg;
  logic               busy_q;
  logic               done_q;
  logic               dz_q;
  logic [WIDTH-1:0]   q_out;
  logic [WIDTH-1:0]   r_out;

  logic               dvd_neg;
  logic               dsr_neg;
  logic [WIDTH-1:0]   dvd_abs;
  logic [WIDTH-1:0]   dsr_abs;
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_diff;
  logic               div_zero;
  logic [WIDTH-1:0]   q_res;
  logic [WIDTH-1:0]   r_res;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    dvd_neg  = 1'b0;
    dsr_neg  = 1'b0;
    dvd_abs  = dvd_q;
    dsr_abs  = dsr_mag;
    q_res    = quo;
    r_res    = rem;
    if (sgn_q) begin
      dvd_neg = dvd_q[WIDTH-1];
      dsr_neg = dsr_mag[WIDTH-1];
    end
    // -MIN wraps back to MIN, which is exactly 2^(WIDTH-1) read as unsigned.
    if (dvd_neg) dvd_abs = -dvd_q;
    if (dsr_neg) dsr_abs = -dsr_mag;

    rem_sh   = {rem, quo[WIDTH-1]};
    rem_ge   = (rem_sh >= {1'b0, dsr_mag});
    // The true difference is below the divisor, so the top bit is always zero.
    rem_diff = rem_sh[WIDTH-1:0] - dsr_mag;

    div_zero = (dsr_mag == '0);
    if (div_zero) begin
      q_res = '1;
      r_res = dvd_q;
    end else begin
      if (q_neg) q_res = -quo;
      if (r_neg) r_res = -rem;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees the pre-edge value of every other register.
  always_ff @(posedge clock_signal or negedge reset_n_signal) begin
    if (!reset_n_signal) begin
      // NOTE: the datapath is a handful of flops, not a memory, so all of it is
      // reset; that also makes an aborted operation leave nothing behind.
      state   <= S_IDLE;
      sgn_q   <= 1'b0;
      dvd_q   <= '0;
      dsr_mag <= '0;
      quo     <= '0;
      rem     <= '0;
      cnt     <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      q_out   <= '0;
      r_out   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (div_bus.start_signal) begin
            sgn_q   <= div_bus.signed_division;
            dvd_q   <= div_bus.dividend_input;
            dsr_mag <= div_bus.divisor_input;
            busy_q  <= 1'b1;
            state   <= S_PREP;
          end
        end
        S_PREP: begin
          quo     <= dvd_abs;
          dsr_mag <= dsr_abs;
          rem     <= '0;
          q_neg   <= dvd_neg ^ dsr_neg;
          r_neg   <= dvd_neg;
          cnt     <= CNT_W'(WIDTH);
          state   <= S_ITER;
        end
        S_ITER: begin
          if (rem_ge) begin
            rem <= rem_diff;
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= rem_sh[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= S_POST;
        end
        S_POST: begin
          q_out  <= q_res;
          r_out  <= r_res;
          dz_q   <= div_zero;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign div_bus.busy_signal      = busy_q;
  assign div_bus.done_signal      = done_q;
  assign div_bus.div_zero_signal  = dz_q;
  assign div_bus.quotient_output  = q_out;
  assign div_bus.remainder_output = r_out;

endmodule
